// File: rtl/rv_pipe_pkg.sv
// Shared MEM->WB pipeline definitions: result-select encodings and the
// payload record carried through the MEM/WB skid stage.
package rv_pipe_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;
   localparam int RS_W_DEF   = 2;

   localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
   localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

   // Field order (MSB first) matches the flat payload built by the stage.
   typedef struct packed {
      logic [XLEN_DEF-1:0]   alu;
      logic [XLEN_DEF-1:0]   rdata;
      logic [XLEN_DEF-1:0]   pc4;
      logic [REG_AW_DEF-1:0] rd;
      logic [RS_W_DEF-1:0]   rsrc;
      logic                  rwr;
   } mem_wb_payload_t;

   localparam int MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry (main + skid) valid/ready register on a flat payload.
// in_ready depends only on registered state, so out_ready never reaches it
// combinationally. flush empties both entries and discards that cycle's input.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_data_q,  main_data_d;
   logic [W-1:0] skid_data_q,  skid_data_d;
   logic         acc;
   logic         deq;

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign acc       = in_valid & ~skid_valid_q;
   assign deq       = main_valid_q & out_ready;

   // Next-state: EMPTY/ONE/FULL transitions; payload only moves on accept/promote.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (acc) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end else if (!skid_valid_q) begin
         if (acc && deq) begin
            main_data_d  = in_data;
         end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else if (deq) begin
            main_valid_d = 1'b0;
         end
      end else if (deq) begin
         main_data_d  = skid_data_q;
         skid_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// Elastic MEM->WB stage: skid buffer plus writeback result select,
// write-enable qualification and a saturating writeback-stall counter.
module mem_wb_skid_stage
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int RS_W   = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   alu_result_m,
   input  logic [XLEN-1:0]   read_data_m,
   input  logic [XLEN-1:0]   pc_plus4_m,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [RS_W-1:0]   result_src_m,
   input  logic              reg_write_m,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_result_w,
   output logic [XLEN-1:0]   read_data_w,
   output logic [XLEN-1:0]   pc_plus4_w,
   output logic [REG_AW-1:0] rd_w,
   output logic [RS_W-1:0]   result_src_w,
   output logic              reg_write_w,
   output logic [XLEN-1:0]   result_w,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = 3*XLEN + REG_AW + RS_W + 1;

   logic [PW-1:0]    in_payload;
   logic [PW-1:0]    out_payload;
   logic             held_rwr;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Same field order as mem_wb_payload_t.
   assign in_payload = {alu_result_m, read_data_m, pc_plus4_m, rd_m, result_src_m, reg_write_m};
   assign {alu_result_w, read_data_w, pc_plus4_w, rd_w, result_src_w, held_rwr} = out_payload;

   pipe_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   // Writes to x0 or from an empty stage must never reach the register file.
   assign reg_write_w = out_valid & held_rwr & (rd_w != '0);

   // Writeback value select; the reserved encoding yields zero.
   always_comb begin
      result_w = '0;
      if (result_src_w == RS_W'(RESULT_SRC_ALU))
         result_w = alu_result_w;
      else if (result_src_w == RS_W'(RESULT_SRC_LOAD))
         result_w = read_data_w;
      else if (result_src_w == RS_W'(RESULT_SRC_PC4))
         result_w = pc_plus4_w;
   end

   // Count cycles where WB holds a valid entry it cannot hand off; saturate.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // Stall counter register, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomised + directed bench for mem_wb_skid_stage against a queue-based model.
module tb_mem_wb_skid_stage;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic [1:0]  rsrc;
      logic        rwr;
   } pl_t;

   logic        clk, rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
   logic [4:0]  rd_m;
   logic [1:0]  result_src_m;
   logic        reg_write_m;
   logic [31:0] alu_result_w, read_data_w, pc_plus4_w, result_w;
   logic [4:0]  rd_w;
   logic [1:0]  result_src_w;
   logic        reg_write_w;
   logic [15:0] stall_cnt;

   logic        s_in_ready, s_out_valid, s_reg_write_w;
   logic [31:0] s_alu, s_rdata, s_pc4, s_result;
   logic [4:0]  s_rd;
   logic [1:0]  s_rsrc;
   logic [3:0]  s_stall_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   pl_t  mq[$];
   int   stall_model = 0;
   int   n_acc = 0;
   logic last_acc;

   mem_wb_skid_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m),
      .rd_m(rd_m), .result_src_m(result_src_m), .reg_write_m(reg_write_m),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_result_w(alu_result_w), .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
      .rd_w(rd_w), .result_src_w(result_src_w), .reg_write_w(reg_write_w),
      .result_w(result_w), .stall_cnt(stall_cnt)
   );

   mem_wb_skid_stage #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m),
      .rd_m(rd_m), .result_src_m(result_src_m), .reg_write_m(reg_write_m),
      .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
      .alu_result_w(s_alu), .read_data_w(s_rdata), .pc_plus4_w(s_pc4),
      .rd_w(s_rd), .result_src_w(s_rsrc), .reg_write_w(s_reg_write_w),
      .result_w(s_result), .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_result(input pl_t p);
      case (p.rsrc)
         2'd0:    return p.alu;
         2'd1:    return p.rdata;
         2'd2:    return p.pc4;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic check_outputs();
      check("out_valid", out_valid, mq.size() > 0);
      check("in_ready", in_ready, mq.size() < 2);
      check("stall_cnt", stall_cnt, sat(stall_model, 65535));
      check("stall_cnt_sat", s_stall_cnt, sat(stall_model, 15));
      check("sat_out_valid", s_out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check("alu_w", alu_result_w, mq[0].alu);
         check("rdata_w", read_data_w, mq[0].rdata);
         check("pc4_w", pc_plus4_w, mq[0].pc4);
         check("rd_w", rd_w, mq[0].rd);
         check("rsrc_w", result_src_w, mq[0].rsrc);
         check("result_w", result_w, exp_result(mq[0]));
         check("reg_write_w", reg_write_w, mq[0].rwr && (mq[0].rd != 0));
      end else begin
         check("reg_write_w_idle", reg_write_w, 1'b0);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic [4:0] r, input logic [1:0] s,
                        input logic w);
      in_valid = v; alu_result_m = a; read_data_m = d; pc_plus4_m = p;
      rd_m = r; result_src_m = s; reg_write_m = w;
   endtask

   task automatic tick();
      bit  acc, deq;
      pl_t p;
      acc = in_valid && (mq.size() < 2);
      deq = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready) stall_model++;
      p.alu = alu_result_m; p.rdata = read_data_m; p.pc4 = pc_plus4_m;
      p.rd = rd_m; p.rsrc = result_src_m; p.rwr = reg_write_m;
      @(posedge clk);
      if (flush) begin
         mq.delete();
         last_acc = 1'b0;
      end else begin
         if (deq) void'(mq.pop_front());
         if (acc) mq.push_back(p);
         last_acc = acc;
      end
      if (last_acc) n_acc++;
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mq.delete();
      stall_model = 0;
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_result_w", result_w, 32'd0);
      check("rst_reg_write_w", reg_write_w, 1'b0);
      check("rst_stall_cnt", stall_cnt, 16'd0);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      #2;
      do_reset();

      // Reset asserted while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 32'h21, 32'h31, 5'd3, 2'd0, 1'b1); tick();
      drive(1'b1, 32'h12, 32'h22, 32'h32, 5'd4, 2'd1, 1'b1); tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0); tick();
      rst = 1'b0;
      #2;
      mq.delete(); stall_model = 0;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_in_ready", in_ready, 1'b1);
      check("async_rst_stall_cnt", stall_cnt, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // Streaming loads, one per cycle
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'hdead0000 + i, 32'h100 + i, 32'h4 * i, 5'(i), 2'd1, 1'b1);
         tick();
         check("stream_result", result_w, 32'h100 + i);
         check("stream_in_ready", in_ready, 1'b1);
      end
      drive(1'b0, 0, 0, 0, 0, 0, 0); tick();

      // Back-pressure with in_valid held
      do_reset();
      n_acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h500 + i, 32'h600 + i, 32'h700 + i, 5'(i + 1), 2'd0, 1'b1);
         tick();
         if (i >= 1) check("bp_in_ready_low", in_ready, 1'b0);
      end
      check("bp_accepted", n_acc, 2);
      check("bp_stall_cnt", stall_cnt, 16'd4);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      out_ready = 1'b1;
      tick(); check("bp_drain1", result_w, 32'h501);
      tick(); check("bp_drain_empty", out_valid, 1'b0);
      check("bp_in_ready_back", in_ready, 1'b1);

      // Flush while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h1, 32'h2, 32'h3, 5'd5, 2'd0, 1'b1); tick();
      drive(1'b1, 32'h4, 32'h5, 32'h6, 5'd6, 2'd0, 1'b1); tick();
      flush = 1'b1;
      drive(1'b1, 32'h7, 32'h8, 32'h9, 5'd7, 2'd0, 1'b1); tick();
      flush = 1'b0;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      out_ready = 1'b1;
      tick(); check("flush_input_absent", out_valid, 1'b0);

      // Write qualification and result select
      drive(1'b1, 32'haaaa, 32'hbbbb, 32'hcccc, 5'd0, 2'd0, 1'b1); tick();
      check("wq_rd0", reg_write_w, 1'b0);
      drive(1'b1, 32'h1234, 32'h5678, 32'h44, 5'd9, 2'd2, 1'b1); tick();
      check("wq_pc4", result_w, 32'h44);
      check("wq_we", reg_write_w, 1'b1);
      drive(1'b1, 32'h1234, 32'h5678, 32'h44, 5'd9, 2'd3, 1'b0); tick();
      check("wq_rsvd", result_w, 32'd0);
      drive(1'b0, 0, 0, 0, 0, 0, 0); tick();

      // Saturating stall counter
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'h9, 32'h9, 32'h9, 5'd2, 2'd0, 1'b1); tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      check("sat_15", s_stall_cnt, 4'd15);
      check("nosat_20", stall_cnt, 16'd20);

      // Random traffic
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 99) < 3);
         tick();
      end
      flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
